// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared defaults, types and helpers for the pipelined carry look-ahead adder
package cla_pkg;

  localparam int CLA_WIDTH_DEF = 16;
  localparam int CLA_BLOCK_DEF = 4;

  typedef struct packed {
    logic p;
    logic g;
  } cla_pg_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_block.sv
// rtl/cla_block.sv - combinational BLOCK-bit look-ahead group with flat two-level carries
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = CLA_BLOCK_DEF
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             group_p,
  output logic             group_g,
  output logic             cmsb
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;
  cla_pg_t          grp;

  // Carry into bit n as one sum-of-products: no ripple through earlier carries.
  function automatic logic carry_into(input logic [BLOCK-1:0] pp, input logic [BLOCK-1:0] gg,
                                      input logic c0, input int n);
    logic term;
    logic acc;
    acc = 1'b0;
    for (int j = 0; j < n; j++) begin
      term = gg[j];
      for (int m = j + 1; m < n; m++) term = term & pp[m];
      acc = acc | term;
    end
    term = c0;
    for (int m = 0; m < n; m++) term = term & pp[m];
    return acc | term;
  endfunction

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = cin;

  for (genvar i = 1; i <= BLOCK; i++) begin : g_carry
    assign c[i] = carry_into(p, g, cin, i);
  end

  assign grp.p   = &p;
  assign grp.g   = carry_into(p, g, 1'b0, BLOCK);
  assign group_p = grp.p;
  assign group_g = grp.g;

  assign sum  = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign cmsb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined CLA, one look-ahead group per stage; PIPELINED_CLA_SIGNED_OVF_EN adds ovf
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH_DEF,
  parameter int BLOCK = CLA_BLOCK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int BLK_SAFE = (BLOCK < 1) ? 1 : BLOCK;
  localparam int STAGES   = WIDTH / BLK_SAFE;

  if (BLOCK < 1 || (WIDTH % BLK_SAFE) != 0) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
  end

  logic stall;

  // Stage k holds finished slices 0..k, its group carry, and the operand slices above k.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO  = k * BLOCK;
    localparam int REM = WIDTH - LO - BLOCK;

    logic [BLOCK-1:0]    blk_a;
    logic [BLOCK-1:0]    blk_b;
    logic [BLOCK-1:0]    blk_sum;
    logic                blk_cin;
    logic                blk_cout;
    logic                blk_p;
    logic                blk_g;
    logic                blk_cmsb;
    logic                v_d;
    logic [LO+BLOCK-1:0] res_d;
    logic                v_q;
    logic [LO+BLOCK-1:0] res_q;
    logic                cout_q;
    logic                unused_grp;

    if (k == 0) begin : g_first
      assign blk_a   = a[BLOCK-1:0];
      assign blk_b   = b[BLOCK-1:0];
      assign blk_cin = cin;
      assign v_d     = in_valid && in_ready;
      assign res_d   = blk_sum;
    end else begin : g_next
      assign blk_a   = g_st[k-1].g_ops.a_q[BLOCK-1:0];
      assign blk_b   = g_st[k-1].g_ops.b_q[BLOCK-1:0];
      assign blk_cin = g_st[k-1].cout_q;
      assign v_d     = g_st[k-1].v_q;
      assign res_d   = {blk_sum, g_st[k-1].res_q};
    end

    cla_block #(.BLOCK(BLOCK)) u_blk (
      .a       (blk_a),
      .b       (blk_b),
      .cin     (blk_cin),
      .sum     (blk_sum),
      .cout    (blk_cout),
      .group_p (blk_p),
      .group_g (blk_g),
      .cmsb    (blk_cmsb)
    );

    assign unused_grp = ^{blk_p, blk_g, blk_cmsb};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q    <= 1'b0;
        res_q  <= '0;
        cout_q <= 1'b0;
      end else if (!stall) begin
        v_q    <= v_d;
        res_q  <= res_d;
        cout_q <= blk_cout;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_src_in
        assign a_d = a[WIDTH-1:BLOCK];
        assign b_d = b[WIDTH-1:BLOCK];
      end else begin : g_src_prev
        assign a_d = g_st[k-1].g_ops.a_q[REM+BLOCK-1:BLOCK];
        assign b_d = g_st[k-1].g_ops.b_q[REM+BLOCK-1:BLOCK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign sum       = {g_st[STAGES-1].cout_q, g_st[STAGES-1].res_q};

`ifdef PIPELINED_CLA_SIGNED_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= g_st[STAGES-1].blk_cmsb ^ g_st[STAGES-1].blk_cout;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder (WIDTH=16, BLOCK=4)
module tb_pipelined_cla_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] sum;
  logic        ovf;

  int tests;
  int fails;
  int n_out;
  int sent;
  int lat;
  int base_out;
  logic        acc;
  logic        rdy_s;
  logic        saw_stall;
  logic        held_vld;
  logic [17:0] held_val;
  logic        use_dir;
  logic [17:0] dir_exp;
  logic [17:0] e;
  logic [17:0] exp_q[$];

`ifdef PIPELINED_CLA_SIGNED_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] ref_sum(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] s;
    logic        o;
    s = {1'b0, x} + {1'b0, y} + {16'd0, c};
    o = OVF_ON && (x[15] == y[15]) && (s[15] != x[15]);
    return {o, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes and score outputs at negedge, return just after posedge.
  task automatic tick();
    @(negedge clk);
    acc   = in_valid && in_ready;
    rdy_s = in_ready;
    if (acc) exp_q.push_back(use_dir ? dir_exp : ref_sum(a, b, cin));
    check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (held_vld) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'({ovf, sum}), 32'(held_val));
    end
    held_vld = out_valid && !out_ready;
    held_val = {ovf, sum};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e[16:0]));
        check("ovf", 32'(ovf), 32'(e[17]));
        n_out++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input logic [17:0] dexp);
    a        = x;
    b        = y;
    cin      = c;
    dir_exp  = dexp;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) tick();
    check("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    n_out     = 0;
    held_vld  = 1'b0;
    use_dir   = 1'b1;
    dir_exp   = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;

    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'h00000);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Single beat and its latency.
    send(16'h1234, 16'h4321, 1'b0, 18'h05555);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("first_sum", 32'(sum), 32'h05555);
    drain();

    // Carries that run through every group, and the signed-overflow corners.
    send(16'hFFFF, 16'h0001, 1'b0, 18'h10000);
    send(16'hFFFF, 16'hFFFF, 1'b1, 18'h1FFFF);
    send(16'h7FFF, 16'h0001, 1'b0, {OVF_ON, 17'h08000});
    send(16'h0003, 16'h0004, 1'b0, 18'h00007);
    send(16'h8000, 16'h8000, 1'b0, {OVF_ON, 17'h10000});
    drain();

    // Eight random back-to-back beats with a three-cycle downstream stall.
    use_dir   = 1'b0;
    base_out  = n_out;
    sent      = 0;
    saw_stall = 1'b0;
    a         = 16'($urandom);
    b         = 16'($urandom);
    cin       = 1'($urandom);
    in_valid  = 1'b1;
    for (int c = 0; c < 60 && (sent < 8 || exp_q.size() > 0); c++) begin
      out_ready = !(c >= 6 && c < 9);
      tick();
      if (!rdy_s) saw_stall = 1'b1;
      if (acc) begin
        sent++;
        if (sent < 8) begin
          a   = 16'($urandom);
          b   = 16'($urandom);
          cin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b1;
    check("stream_sent", 32'(sent), 32'd8);
    check("stream_out", 32'(n_out - base_out), 32'd8);
    check("stream_stalled", 32'(saw_stall), 32'd1);
    check("stream_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three beats in flight.
    send(16'($urandom), 16'($urandom), 1'b0, 18'h0);
    send(16'($urandom), 16'($urandom), 1'b1, 18'h0);
    send(16'($urandom), 16'($urandom), 1'b0, 18'h0);
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(sum), 32'h00000);
    exp_q.delete();
    held_vld = 1'b0;
    tick();
    rst_n    = 1'b1;
    base_out = n_out;
    for (int n = 0; n < 12; n++) tick();
    check("no_stale_out", 32'(n_out - base_out), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Pipeline still healthy after reset.
    use_dir = 1'b0;
    for (int n = 0; n < 6; n++) send(16'($urandom), 16'($urandom), 1'($urandom), 18'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
